// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: stereo I2S/left-justified serial transmitter with input frame FIFO; ports clk/rst, en, mode, s_valid/s_ready/s_left/s_right in, bclk/lrclk/sdata/underrun/fifo_level out
module i2s_tx_fifo #(
  parameter int DATA_W = 16,
  parameter int SLOT_W = 32,
  parameter int CLK_DIV = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          mode,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_left,
  input  logic [DATA_W-1:0]             s_right,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          sdata,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int LW = 2 * SLOT_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DVW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(LW);
  logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [DVW-1:0] div;
  logic [BW-1:0] bitcnt, nbit;
  logic [LW-1:0] sr, ld, src;
  logic dly, mode_l, en_d;
  logic push, pop, have, start_en, tc, step, fs, lj, mode_n;
  assign s_ready = fifo_level < (AW+1)'(FIFO_DEPTH);
  assign push = s_valid && s_ready;
  assign have = fifo_level != '0;
  assign start_en = en && !en_d;
  assign tc = div == DVW'(CLK_DIV - 1);
  // a bit step is the falling bclk toggle of a running divider
  assign step = en && en_d && tc && bclk;
  assign fs = start_en || (step && bitcnt == BW'(LW - 1));
  assign pop = fs && have;
  assign ld = have ? (LW'(mem[rp][2*DATA_W-1:DATA_W]) << (LW - DATA_W)) |
                     (LW'(mem[rp][DATA_W-1:0]) << (SLOT_W - DATA_W)) : '0;
  assign src = fs ? ld : sr;
  assign lj = src[LW-1];
  assign nbit = fs ? '0 : bitcnt + BW'(1);
  assign mode_n = fs ? mode : mode_l;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {s_left, s_right};
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      fifo_level <= '0;
      en_d <= 1'b0;
      underrun <= 1'b0;
      div <= '0;
      bclk <= 1'b0;
      bitcnt <= '0;
      sr <= '0;
      dly <= 1'b0;
      mode_l <= 1'b0;
      lrclk <= 1'b0;
      sdata <= 1'b0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
      en_d <= en;
      underrun <= fs && !have;
      if (!en) begin
        div <= '0;
        bclk <= 1'b0;
        bitcnt <= '0;
        sr <= '0;
        dly <= 1'b0;
        mode_l <= 1'b0;
        lrclk <= 1'b0;
        sdata <= 1'b0;
      end else begin
        div <= (start_en || tc) ? '0 : div + DVW'(1);
        bclk <= start_en ? 1'b0 : (tc ? !bclk : bclk);
        if (fs || step) begin
          bitcnt <= nbit;
          sr <= src << 1;
          dly <= lj;
          mode_l <= mode_n;
          lrclk <= nbit >= BW'(SLOT_W);
          // I2S emits the previous step's left-justified bit, so data lags lrclk by one BCLK
          sdata <= mode_n ? lj : dly;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx_fifo.sv
// tb_i2s_tx_fifo: randomized and directed bench with a frame-level reference model
module tb_i2s_tx_fifo;
  localparam int DEPTH = 4;
  localparam int FR = 256;
  logic clk = 0, rst = 1, en = 0, mode = 0, s_valid = 0;
  logic [15:0] s_left = 0, s_right = 0;
  logic s_ready, bclk, lrclk, sdata, underrun;
  logic [2:0] fifo_level;
  logic en2 = 0, v2 = 0;
  logic [15:0] l2 = 0, r2 = 0;
  logic rdy2, bclk2, lrclk2, sdata2, und2;
  logic [1:0] lvl2;
  int checks = 0, errors = 0;
  bit m_run = 0, m_und = 0, m_prev = 0, m_mode = 0;
  int m_t = 0;
  logic [63:0] m_cur = 0, cap;
  logic [31:0] m_q[$];
  int lvl_keep;

  i2s_tx_fifo dut (.clk(clk), .rst(rst), .en(en), .mode(mode), .s_valid(s_valid), .s_ready(s_ready),
    .s_left(s_left), .s_right(s_right), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .underrun(underrun), .fifo_level(fifo_level));

  i2s_tx_fifo #(.DATA_W(16), .SLOT_W(16), .CLK_DIV(1), .FIFO_DEPTH(2)) dut2 (.clk(clk), .rst(rst),
    .en(en2), .mode(1'b0), .s_valid(v2), .s_ready(rdy2), .s_left(l2), .s_right(r2), .bclk(bclk2),
    .lrclk(lrclk2), .sdata(sdata2), .underrun(und2), .fifo_level(lvl2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model();
    int sz = m_q.size();
    logic [31:0] f;
    m_und = 0;
    if (rst) begin
      m_run = 0;
      m_q.delete();
    end else begin
      if (!en) m_run = 0;
      else begin
        if (!m_run || (m_t + 1) % FR == 0) begin
          m_prev = m_run ? m_cur[0] : 1'b0;
          m_mode = mode;
          if (sz > 0) begin
            f = m_q.pop_front();
            m_cur = {f[31:16], 16'h0, f[15:0], 16'h0};
          end else begin
            m_cur = '0;
            m_und = 1;
          end
        end
        m_t = m_run ? m_t + 1 : 0;
        m_run = 1;
      end
      if (s_valid && sz < DEPTH) m_q.push_back({s_left, s_right});
    end
  endtask

  task automatic compare();
    int b = (m_t / 4) % 64;
    logic e_sd = m_mode ? m_cur[63-b] : (b == 0 ? m_prev : m_cur[64-b]);
    chk("bclk", 64'(bclk), m_run ? 64'((m_t / 2) % 2) : 64'(0));
    chk("lrclk", 64'(lrclk), m_run ? 64'(b >= 32) : 64'(0));
    chk("sdata", 64'(sdata), m_run ? 64'(e_sd) : 64'(0));
    chk("underrun", 64'(underrun), 64'(m_und));
    chk("fifo_level", 64'(fifo_level), 64'(m_q.size()));
    chk("s_ready", 64'(s_ready), 64'(m_q.size() < DEPTH));
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    @(negedge clk);
    compare();
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (!(m_run && m_t == target) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk("run_to_timeout", 64'(m_t), 64'(target));
  endtask

  task automatic push1(input logic [15:0] l, input logic [15:0] r);
    s_valid = 1; s_left = l; s_right = r;
    tick();
    s_valid = 0;
  endtask

  task automatic capture();
    cap = '0;
    for (int i = 0; i < FR; i++) begin
      tick();
      if (m_t % 4 == 2) cap[63 - (m_t / 4)] = sdata;
      if (m_t == 127) chk("lrclk_before_half", 64'(lrclk), 64'(0));
      if (m_t == 128) chk("lrclk_at_half", 64'(lrclk), 64'(1));
    end
  endtask

  initial begin
    repeat (3) tick();
    rst = 0;
    tick();
    chk("reset_level", 64'(fifo_level), 64'(0));
    chk("reset_ready", 64'(s_ready), 64'(1));
    chk("reset_pins", 64'({bclk, lrclk, sdata, underrun}), 64'(0));
    // SLOT_W=DATA_W instance: I2S right LSB lands at bitcnt 0 of the following frame
    v2 = 1; l2 = 16'hA5C3; r2 = 16'h8001;
    tick();
    v2 = 0; en2 = 1;
    for (int i = 0; i <= 64; i++) begin
      tick();
      if (i == 0) chk("d2_bit0", 64'(sdata2), 64'(0));
      if (i == 1) chk("d2_bclk_hi", 64'(bclk2), 64'(1));
      if (i == 2) chk("d2_msb", 64'(sdata2), 64'(1));
      if (i == 64) chk("d2_rlsb_next", 64'(sdata2), 64'(1));
      if (i == 64) chk("d2_underrun", 64'(und2), 64'(1));
    end
    en2 = 0;
    // left-justified frame
    mode = 1;
    push1(16'hA5C3, 16'h8001);
    en = 1;
    capture();
    chk("lj_stream", cap, 64'hA5C3_0000_8001_0000);
    tick();
    chk("lj_next_underrun", 64'(underrun), 64'(1));
    // I2S frame
    en = 0;
    tick();
    mode = 0;
    push1(16'hA5C3, 16'h8001);
    en = 1;
    capture();
    chk("i2s_stream", cap, 64'h52E1_8000_4000_8000);
    // backpressure
    en = 0;
    tick();
    s_valid = 1;
    for (int i = 0; i < 8; i++) begin
      s_left = 16'($urandom); s_right = 16'($urandom);
      tick();
    end
    s_valid = 0;
    chk("bp_level", 64'(fifo_level), 64'(4));
    chk("bp_ready", 64'(s_ready), 64'(0));
    en = 1;
    tick();
    chk("bp_ready_after_pop", 64'(s_ready), 64'(1));
    chk("bp_level_after_pop", 64'(fifo_level), 64'(3));
    // underrun from empty, then mid-frame push
    rst = 1;
    tick();
    rst = 0; en = 1; mode = 1;
    tick();
    chk("ur_first", 64'(underrun), 64'(1));
    run_to(100);
    push1(16'h1234, 16'hFEDC);
    run_to(256);
    chk("ur_none_when_data", 64'(underrun), 64'(0));
    // push exactly in frame-start cycle: empty, then level 1
    run_to(511);
    s_valid = 1; s_left = 16'h0F0F; s_right = 16'h7007;
    tick();
    s_valid = 0;
    chk("sim_empty_underrun", 64'(underrun), 64'(1));
    chk("sim_empty_level", 64'(fifo_level), 64'(1));
    run_to(767);
    s_valid = 1; s_left = 16'hBEEF; s_right = 16'h0001;
    tick();
    s_valid = 0;
    chk("sim_one_underrun", 64'(underrun), 64'(0));
    chk("sim_one_level", 64'(fifo_level), 64'(1));
    // en drop mid-frame
    run_to(1030);
    push1(16'hC001, 16'h0C0D);
    run_to(1065);
    lvl_keep = fifo_level;
    en = 0;
    tick();
    chk("en_drop_pins", 64'({bclk, lrclk, sdata}), 64'(0));
    chk("en_drop_level", 64'(fifo_level), 64'(lvl_keep));
    en = 1;
    tick();
    chk("reen_t0_pop", 64'(fifo_level), 64'(lvl_keep - 1));
    // reset mid-frame
    run_to(150);
    push1(16'h5555, 16'hAAAA);
    run_to(161);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_level", 64'(fifo_level), 64'(0));
    chk("rst_pins", 64'({bclk, lrclk, sdata, underrun}), 64'(0));
    // randomized traffic
    for (int i = 0; i < 6000; i++) begin
      rst = ($urandom % 1500) == 0;
      if ($urandom % 400 == 0) en = !en;
      mode = 1'($urandom);
      s_valid = ($urandom % 100) < (i < 3000 ? 1 : 5);
      s_left = 16'($urandom); s_right = 16'($urandom);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2s_tx_fifo.md
Name: i2s_tx_fifo

Overview:
- Parametrised stereo I2S/left-justified serial transmitter with an input frame FIFO.
- Generates BCLK, LRCLK and SDATA from the single system clock.
- Sits between the sample-processing datapath (valid/ready source) and the chip output pins of the toi2s design.
- Supersedes a fixed-format serializer: configurable sample/slot width, BCLK divider, FIFO depth, runtime format select, underrun reporting.

Parameters:
- DATA_W, 16: sample width in bits; must be at least 1.
- SLOT_W, 32: BCLK periods per channel slot; must be at least DATA_W.
- CLK_DIV, 2: clk cycles per BCLK half-period; must be at least 1.
- FIFO_DEPTH, 4: stereo frames buffered; power of 2, at least 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  transmit enable.
- mode  in  1  0 = I2S (data one BCLK after LRCLK edge), 1 = left-justified; sampled only at frame start.
- s_valid  in  1  input frame valid.
- s_ready  out  1  FIFO can accept a frame.
- s_left  in  DATA_W  left sample, two's complement.
- s_right  in  DATA_W  right sample.
- bclk  out  1  bit clock.
- lrclk  out  1  0 = left slot, 1 = right slot.
- sdata  out  1  serial data, MSB first.
- underrun  out  1  one-cycle pulse when a frame starts with the FIFO empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  frames stored.

Behaviour:
- Reset: bclk=0, lrclk=0, sdata=0, underrun=0, fifo_level=0, s_ready=1. FIFO, divider, bit counter and shifters cleared. Reset mid-frame aborts the frame and discards FIFO contents.
- FIFO:
  - Push when s_valid and s_ready; s_ready = (fifo_level < FIFO_DEPTH), combinational from registered level.
  - Pop happens only at frame start.
  - Push and pop in the same cycle leave the level unchanged.
  - A pop decision uses the level registered before the current cycle: a push into an empty FIFO in the same cycle as a frame start does not satisfy that frame; underrun fires and the data stays queued.
- Divider:
  - Counter 0..CLK_DIV-1 runs while en=1. At terminal count it wraps and bclk toggles.
  - A falling toggle (1 to 0) is a bit step.
- Frame:
  - bitcnt 0..2*SLOT_W-1 increments on each bit step and wraps to 0. The wrap is a frame start.
  - lrclk = (bitcnt >= SLOT_W) in left-justified mode.
  - In I2S mode lrclk follows the same rule, giving each slot SLOT_W BCLKs.
  - lrclk and sdata change only on bit steps and are registered.
- Frame start:
  - If the FIFO is non-empty, pop into a 2*SLOT_W shift register: left MSB-aligned in bits [2*SLOT_W-1:2*SLOT_W-DATA_W], right MSB-aligned in bits [SLOT_W-1:SLOT_W-DATA_W], zeros elsewhere.
  - If empty, load all zeros and pulse underrun for one clk.
  - Latch mode.
- Data output:
  - LJ: sdata = shift-register MSB; shift left on each bit step.
  - I2S: sdata = LJ bit delayed by one bit step. The delay register carries across the frame boundary; when SLOT_W=DATA_W, the right LSB appears at bitcnt 0 of the next frame.
- Enable:
  - en 0 to 1: on the first en=1 cycle a frame start occurs with bitcnt=0, bclk=0, and the divider restarted. The I2S delay bit is 0.
  - en=0: on the next clk, bclk, lrclk and sdata are forced to 0, and the divider, bitcnt and shifters are cleared.
  - The partial frame is discarded, not re-queued. FIFO contents are kept and pushes still accepted.
  - No underrun pulses while en=0.
- Timing: frame length = 4*SLOT_W*CLK_DIV clk cycles.

Test Plan:
- Basic LJ, defaults, mode=1:
  - Stimulus: push L=16'hA5C3, R=16'h8001; then en=1.
  - Response: bclk period 4 clks; lrclk low 32 BCLKs then high 32; sdata = A5C3 MSB-first then 16 zeros, then 8001 then 16 zeros; frame = 256 clks.
- I2S mode=0, same data:
  - Response: at bitcnt 0 sdata=0; A5C3 bits at bitcnt 1..16.
  - Check with SLOT_W=DATA_W=16: R LSB (1) appears at bitcnt 0 of the next frame.
- Backpressure:
  - Stimulus: en=0; push with s_valid held high.
  - Response: exactly 4 accepted; s_ready=0 and fifo_level=4. Set en=1: the pop at the first frame start makes s_ready=1 on the next cycle.
- Underrun:
  - Stimulus: en=1 with an empty FIFO; push a frame mid-frame.
  - Response: underrun one-cycle pulse at the first frame start, sdata all 0 for that frame; the next frame transmits the pushed data with no pulse.
- Simultaneous push/pop:
  - Stimulus: push in the exact frame-start cycle, with level=1 and with level=0.
  - Response: level stays 1; with level=0, underrun pulses and level becomes 1.
- Abort paths:
  - Stimulus: drop en at bitcnt 10; separately assert rst at bitcnt 40.
  - Response: en drop gives outputs 0 next cycle, FIFO level unchanged, re-enable starts a new frame with the next entry. rst clears level to 0 with outputs 0.
